// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the countdown front-panel controller.
package countdown_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_ALARM = 3'd4
  } state_t;

  // Key vector layout
  localparam int unsigned KEY_N     = 4;
  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_SET   = 1;
  localparam int unsigned KEY_UP    = 2;
  localparam int unsigned KEY_DOWN  = 3;

  // Default parameter values
  localparam int unsigned CD_DEFAULT_SECS = 60;
  localparam int unsigned CD_MAX_SECS     = 5999;
  localparam int unsigned CD_STEP         = 1;
  localparam int unsigned CD_ALARM_TICKS  = 30;

endpackage

// File: rtl/key_edge.sv
// Registered rising-edge detector for debounced key levels.
module key_edge #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev_q;

  // Previous level resets high so a key held through reset gives no event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '1;
      rise   <= '0;
    end else begin
      prev_q <= level;
      rise   <= level & ~prev_q;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Front-panel controller: key events drive preset editing, run/pause and alarm.
module countdown_sequencer
  import countdown_ctrl_pkg::*;
#(
  parameter int unsigned DEFAULT_SECS = CD_DEFAULT_SECS,
  parameter int unsigned MAX_SECS     = CD_MAX_SECS,
  parameter int unsigned STEP         = CD_STEP,
  parameter int unsigned ALARM_TICKS  = CD_ALARM_TICKS
) (
  input  logic        CLK,
  input  logic        resetN,
  input  logic        tick,
  input  logic        keyStartStop,
  input  logic        keySet,
  input  logic        keyUp,
  input  logic        keyDown,
  input  logic        done,
  output logic [31:0] initialValue,
  output logic        start,
  output logic        change,
  output logic        active,
  output logic        alarm,
  output logic [2:0]  state
);

  localparam int unsigned PRESET_W = $clog2(MAX_SECS + 1);
  localparam int unsigned ALARM_W  = $clog2(ALARM_TICKS + 1);

  logic [KEY_N-1:0]    keys;
  logic [KEY_N-1:0]    edges;
  logic [KEY_N-1:0]    sel;
  state_t              fsm_q;
  logic [PRESET_W-1:0] preset_q;
  logic [PRESET_W-1:0] preset_up;
  logic [PRESET_W-1:0] preset_dn;
  logic [ALARM_W-1:0]  alarm_cnt_q;
  logic                change_q;
  logic                alarm_q;
  logic [31:0]         init_q;

  // Gather key levels into the package layout
  always_comb begin
    keys            = '0;
    keys[KEY_START] = keyStartStop;
    keys[KEY_SET]   = keySet;
    keys[KEY_UP]    = keyUp;
    keys[KEY_DOWN]  = keyDown;
  end

  key_edge #(.W(KEY_N)) u_key_edge (
    .clk   (CLK),
    .rst_n (resetN),
    .level (keys),
    .rise  (edges)
  );

  // Pick one event per cycle; none while a reload pulse is out, so change never repeats
  always_comb begin
    sel = '0;
    if (!change_q) begin
      if (edges[KEY_START])     sel[KEY_START] = 1'b1;
      else if (edges[KEY_SET])  sel[KEY_SET]   = 1'b1;
      else if (edges[KEY_UP])   sel[KEY_UP]    = 1'b1;
      else if (edges[KEY_DOWN]) sel[KEY_DOWN]  = 1'b1;
    end
  end

  // Saturating preset step up/down
  always_comb begin
    preset_up = PRESET_W'(MAX_SECS);
    preset_dn = '0;
    if (32'(preset_q) + STEP < MAX_SECS) preset_up = PRESET_W'(32'(preset_q) + STEP);
    if (32'(preset_q) >= STEP)           preset_dn = PRESET_W'(32'(preset_q) - STEP);
  end

  // Controller FSM with preset, reload pulse and alarm counter
  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      fsm_q       <= S_IDLE;
      preset_q    <= PRESET_W'(DEFAULT_SECS);
      init_q      <= 32'(DEFAULT_SECS);
      change_q    <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      change_q <= 1'b0;
      unique case (fsm_q)
        S_IDLE: begin
          if (sel[KEY_START]) begin
            if (preset_q != '0) begin
              fsm_q    <= S_RUN;
              change_q <= 1'b1;
            end
          end else if (sel[KEY_SET]) begin
            fsm_q <= S_SET;
          end
        end
        S_SET: begin
          if (sel[KEY_SET]) begin
            fsm_q    <= S_IDLE;
            change_q <= 1'b1;
          end else if (sel[KEY_UP]) begin
            preset_q <= preset_up;
            init_q   <= 32'(preset_up);
          end else if (sel[KEY_DOWN]) begin
            preset_q <= preset_dn;
            init_q   <= 32'(preset_dn);
          end
        end
        S_RUN: begin
          if (done) begin
            fsm_q       <= S_ALARM;
            alarm_q     <= 1'b1;
            alarm_cnt_q <= '0;
          end else if (sel[KEY_START]) begin
            fsm_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (sel[KEY_START]) begin
            fsm_q <= S_RUN;
          end else if (sel[KEY_SET]) begin
            fsm_q    <= S_IDLE;
            change_q <= 1'b1;
          end
        end
        S_ALARM: begin
          if ((|sel) || (tick && alarm_cnt_q == ALARM_W'(ALARM_TICKS - 1))) begin
            fsm_q       <= S_IDLE;
            change_q    <= 1'b1;
            alarm_q     <= 1'b0;
            alarm_cnt_q <= '0;
          end else if (tick) begin
            alarm_cnt_q <= alarm_cnt_q + ALARM_W'(1);
          end
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign start        = tick & (fsm_q == S_RUN);
  assign change       = change_q;
  assign active       = 1'b1;
  assign alarm        = alarm_q;
  assign state        = fsm_q;
  assign initialValue = init_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed self-checking bench for countdown_sequencer.
module tb_countdown_sequencer;

  logic        CLK = 1'b0;
  logic        resetN;
  logic        tick;
  logic [3:0]  key;
  logic        done;
  logic [31:0] initialValue;
  logic        start;
  logic        change;
  logic        active;
  logic        alarm;
  logic [2:0]  state;

  int checks = 0;
  int fails  = 0;

  localparam int K_START = 0;
  localparam int K_SET   = 1;
  localparam int K_UP    = 2;
  localparam int K_DOWN  = 3;

  always #5 CLK = ~CLK;

  countdown_sequencer dut (
    .CLK          (CLK),
    .resetN       (resetN),
    .tick         (tick),
    .keyStartStop (key[0]),
    .keySet       (key[1]),
    .keyUp        (key[2]),
    .keyDown      (key[3]),
    .done         (done),
    .initialValue (initialValue),
    .start        (start),
    .change       (change),
    .active       (active),
    .alarm        (alarm),
    .state        (state)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Key rises, edge registers on next clock, FSM reacts one clock later
  task automatic press(input int k);
    key[k] = 1'b1;
    step(1);
    key[k] = 1'b0;
    step(1);
  endtask

  // One-cycle tick; s is start sampled mid-cycle while tick is high
  task automatic pulse_tick(output logic s);
    tick = 1'b1;
    #1;
    s = start;
    step(1);
    tick = 1'b0;
  endtask

  task automatic test_reset;
    resetN = 1'b0; tick = 1'b0; key = 4'b0; done = 1'b0;
    step(2);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (initialValue !== 32'd60) begin fails++; $display("FAIL reset_init: got %0d want 60", initialValue); end
    checks++; if ({start, change, active, alarm} !== 4'b0010) begin fails++; $display("FAIL reset_outs: got %b want 0010", {start, change, active, alarm}); end
    resetN = 1'b1;
    step(2);
  endtask

  task automatic test_run;
    logic s;
    int   pulses;
    press(K_START);
    checks++; if (state !== 3'd2) begin fails++; $display("FAIL run_state: got %0d want 2", state); end
    checks++; if (change !== 1'b1) begin fails++; $display("FAIL run_change_hi: got %b want 1", change); end
    step(1);
    checks++; if (change !== 1'b0) begin fails++; $display("FAIL run_change_lo: got %b want 0", change); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pulse_tick(s);
      if (s === 1'b1) pulses++;
      step(1);
      checks++; if (start !== 1'b0) begin fails++; $display("FAIL run_start_idle: got %b want 0", start); end
    end
    checks++; if (pulses != 5) begin fails++; $display("FAIL run_start_count: got %0d want 5", pulses); end
  endtask

  task automatic test_pause_resume;
    logic s;
    press(K_START);
    checks++; if (state !== 3'd3) begin fails++; $display("FAIL pause_state: got %0d want 3", state); end
    for (int i = 0; i < 3; i++) begin
      pulse_tick(s);
      checks++; if (s !== 1'b0) begin fails++; $display("FAIL pause_start: got %b want 0", s); end
    end
    press(K_START);
    checks++; if (state !== 3'd2) begin fails++; $display("FAIL resume_state: got %0d want 2", state); end
    pulse_tick(s);
    checks++; if (s !== 1'b1) begin fails++; $display("FAIL resume_start: got %b want 1", s); end
    press(K_START);
    press(K_SET);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL abandon_state: got %0d want 0", state); end
    checks++; if (change !== 1'b1) begin fails++; $display("FAIL abandon_change: got %b want 1", change); end
    step(1);
  endtask

  task automatic test_preset_edit;
    press(K_SET);
    checks++; if (state !== 3'd1) begin fails++; $display("FAIL set_state: got %0d want 1", state); end
    press(K_UP); press(K_UP); press(K_UP); press(K_DOWN);
    checks++; if (change !== 1'b0) begin fails++; $display("FAIL edit_change: got %b want 0", change); end
    press(K_SET);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL edit_exit_state: got %0d want 0", state); end
    checks++; if (change !== 1'b1) begin fails++; $display("FAIL edit_exit_change: got %b want 1", change); end
    checks++; if (initialValue !== 32'd62) begin fails++; $display("FAIL edit_init: got %0d want 62", initialValue); end
    step(1);
  endtask

  task automatic test_saturation;
    press(K_SET);
    for (int i = 0; i < 5940; i++) press(K_UP);
    checks++; if (initialValue !== 32'd5999) begin fails++; $display("FAIL sat_max: got %0d want 5999", initialValue); end
    for (int i = 0; i < 6002; i++) press(K_DOWN);
    checks++; if (initialValue !== 32'd0) begin fails++; $display("FAIL sat_min: got %0d want 0", initialValue); end
    press(K_SET);
    step(1);
    press(K_START);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL zero_start_state: got %0d want 0", state); end
    checks++; if (change !== 1'b0) begin fails++; $display("FAIL zero_start_change: got %b want 0", change); end
    press(K_SET); press(K_UP); press(K_UP); press(K_UP); press(K_SET);
    checks++; if (initialValue !== 32'd3) begin fails++; $display("FAIL restore_init: got %0d want 3", initialValue); end
    step(1);
  endtask

  task automatic test_done_alarm;
    logic s;
    press(K_START);
    step(1);
    key[K_START] = 1'b1;
    step(1);
    done = 1'b1;
    step(1);
    key[K_START] = 1'b0;
    done = 1'b0;
    checks++; if (state !== 3'd4) begin fails++; $display("FAIL done_state: got %0d want 4", state); end
    checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL done_alarm: got %b want 1", alarm); end
    for (int i = 0; i < 29; i++) pulse_tick(s);
    checks++; if (state !== 3'd4) begin fails++; $display("FAIL alarm_hold_state: got %0d want 4", state); end
    pulse_tick(s);
    checks++; if (state !== 3'd0) begin fails++; $display("FAIL timeout_state: got %0d want 0", state); end
    checks++; if ({alarm, change} !== 2'b01) begin fails++; $display("FAIL timeout_outs: got %b want 01", {alarm, change}); end
    step(1);
    checks++; if (change !== 1'b0) begin fails++; $display("FAIL timeout_single: got %b want 0", change); end
  endtask

  task automatic test_back_to_back;
    press(K_SET);
    key[K_UP] = 1'b1; key[K_DOWN] = 1'b1;
    step(1);
    key[K_UP] = 1'b0; key[K_DOWN] = 1'b0;
    step(1);
    checks++; if (initialValue !== 32'd4) begin fails++; $display("FAIL prio_updown: got %0d want 4", initialValue); end
    press(K_SET);
    step(1);
    // Key event and tick together in ALARM exit once
    press(K_START);
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++; if (state !== 3'd4) begin fails++; $display("FAIL alarm2_state: got %0d want 4", state); end
    key[K_SET] = 1'b1;
    step(1);
    tick = 1'b1;
    step(1);
    tick = 1'b0; key[K_SET] = 1'b0;
    checks++; if ({state, change} !== {3'd0, 1'b1}) begin fails++; $display("FAIL key_tick_exit: got %0d/%b want 0/1", state, change); end
    step(1);
    checks++; if (change !== 1'b0) begin fails++; $display("FAIL key_tick_single: got %b want 0", change); end
  endtask

  task automatic test_reset_in_alarm;
    press(K_START);
    done = 1'b1;
    step(1);
    done = 1'b0;
    checks++; if (alarm !== 1'b1) begin fails++; $display("FAIL pre_reset_alarm: got %b want 1", alarm); end
    #2;
    resetN = 1'b0;
    #1;
    checks++; if ({state, alarm, change} !== 5'b00000) begin fails++; $display("FAIL async_reset: got %b want 00000", {state, alarm, change}); end
    checks++; if (initialValue !== 32'd60) begin fails++; $display("FAIL async_reset_init: got %0d want 60", initialValue); end
    step(1);
    resetN = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset;
    test_run;
    test_pause_resume;
    test_preset_edit;
    test_saturation;
    test_done_alarm;
    test_back_to_back;
    test_reset_in_alarm;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
